// File: rtl/seq_cmp_tracker.sv
// Streaming signed/unsigned magnitude comparator with per-frame gt/eq/lt totals.
// One-cycle registered result beat with valid/ready backpressure and frame abort.
module seq_cmp_tracker #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_mode,
    input  logic             i_last,
    input  logic             i_clear,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_agtb,
    output logic             o_aeqb,
    output logic             o_altb,
    output logic             o_frame_valid,
    output logic [CNT_W-1:0] o_gt_cnt,
    output logic [CNT_W-1:0] o_eq_cnt,
    output logic [CNT_W-1:0] o_lt_cnt
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
        if (inc && (cnt != {CNT_W{1'b1}}))
            return cnt + CNT_W'(1);
        return cnt;
    endfunction

    logic signed [WIDTH:0] w_a_ext;
    logic signed [WIDTH:0] w_b_ext;
    logic                  w_gt;
    logic                  w_eq;
    logic                  w_lt;
    logic                  w_in_xfer;
    logic                  w_out_xfer;
    logic [CNT_W-1:0]      w_gt_base;
    logic [CNT_W-1:0]      w_eq_base;
    logic [CNT_W-1:0]      w_lt_base;
    logic [CNT_W-1:0]      w_gt_nxt;
    logic [CNT_W-1:0]      w_eq_nxt;
    logic [CNT_W-1:0]      w_lt_nxt;

    logic [CNT_W-1:0]      r_gt_cnt;
    logic [CNT_W-1:0]      r_eq_cnt;
    logic [CNT_W-1:0]      r_lt_cnt;

    logic                  r_vld_p1;
    logic                  r_agtb_p1;
    logic                  r_aeqb_p1;
    logic                  r_altb_p1;
    logic                  r_fv_p1;
    logic [CNT_W-1:0]      r_gt_tot_p1;
    logic [CNT_W-1:0]      r_eq_tot_p1;
    logic [CNT_W-1:0]      r_lt_tot_p1;

    // One extra bit lets a single signed compare cover both modes.
    assign w_a_ext = {i_mode & i_a[WIDTH-1], i_a};
    assign w_b_ext = {i_mode & i_b[WIDTH-1], i_b};
    assign w_gt    = (w_a_ext > w_b_ext);
    assign w_lt    = (w_a_ext < w_b_ext);
    assign w_eq    = !w_gt && !w_lt;

    assign o_in_ready = (!r_vld_p1 || i_out_ready) && !i_clear;
    assign w_in_xfer  = i_in_valid && o_in_ready;
    assign w_out_xfer = r_vld_p1 && i_out_ready;

    // A frame opened from IDLE always starts counting from zero.
    assign w_gt_base = (r_state == RUN) ? r_gt_cnt : '0;
    assign w_eq_base = (r_state == RUN) ? r_eq_cnt : '0;
    assign w_lt_base = (r_state == RUN) ? r_lt_cnt : '0;
    assign w_gt_nxt  = sat_inc(w_gt_base, w_gt);
    assign w_eq_nxt  = sat_inc(w_eq_base, w_eq);
    assign w_lt_nxt  = sat_inc(w_lt_base, w_lt);

    always_comb begin
        w_state_nxt = r_state;
        if (i_clear)
            w_state_nxt = IDLE;
        else if (w_in_xfer)
            w_state_nxt = i_last ? IDLE : RUN;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_gt_cnt <= '0;
            r_eq_cnt <= '0;
            r_lt_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (i_clear || (w_in_xfer && i_last)) begin
                r_gt_cnt <= '0;
                r_eq_cnt <= '0;
                r_lt_cnt <= '0;
            end else if (w_in_xfer) begin
                r_gt_cnt <= w_gt_nxt;
                r_eq_cnt <= w_eq_nxt;
                r_lt_cnt <= w_lt_nxt;
            end
        end
    end

    // Stage p1: registered result beat
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_vld_p1    <= 1'b0;
            r_agtb_p1   <= 1'b0;
            r_aeqb_p1   <= 1'b0;
            r_altb_p1   <= 1'b0;
            r_fv_p1     <= 1'b0;
            r_gt_tot_p1 <= '0;
            r_eq_tot_p1 <= '0;
            r_lt_tot_p1 <= '0;
        end else if (w_in_xfer) begin
            r_vld_p1    <= 1'b1;
            r_agtb_p1   <= w_gt;
            r_aeqb_p1   <= w_eq;
            r_altb_p1   <= w_lt;
            r_fv_p1     <= i_last;
            r_gt_tot_p1 <= i_last ? w_gt_nxt : '0;
            r_eq_tot_p1 <= i_last ? w_eq_nxt : '0;
            r_lt_tot_p1 <= i_last ? w_lt_nxt : '0;
        end else if (w_out_xfer) begin
            r_vld_p1    <= 1'b0;
            r_agtb_p1   <= 1'b0;
            r_aeqb_p1   <= 1'b0;
            r_altb_p1   <= 1'b0;
            r_fv_p1     <= 1'b0;
            r_gt_tot_p1 <= '0;
            r_eq_tot_p1 <= '0;
            r_lt_tot_p1 <= '0;
        end
    end

    assign o_out_valid   = r_vld_p1;
    assign o_agtb        = r_agtb_p1;
    assign o_aeqb        = r_aeqb_p1;
    assign o_altb        = r_altb_p1;
    assign o_frame_valid = r_fv_p1;
    assign o_gt_cnt      = r_gt_tot_p1;
    assign o_eq_cnt      = r_eq_tot_p1;
    assign o_lt_cnt      = r_lt_tot_p1;

endmodule

// File: tb/tb_seq_cmp_tracker.sv
// Scoreboard bench for seq_cmp_tracker: directed pairs push hand-computed beats,
// a negedge monitor pops and compares every accepted output beat.
module tb_seq_cmp_tracker;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    typedef struct packed {
        logic       gt;
        logic       eq;
        logic       lt;
        logic       fv;
        logic [7:0] gc;
        logic [7:0] ec;
        logic [7:0] lc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mode;
    logic             last;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic             agtb;
    logic             aeqb;
    logic             altb;
    logic             frame_valid;
    logic [CNT_W-1:0] gt_cnt;
    logic [CNT_W-1:0] eq_cnt;
    logic [CNT_W-1:0] lt_cnt;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    seq_cmp_tracker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_a(a), .i_b(b), .i_mode(mode),
        .i_last(last), .i_clear(clear), .i_in_valid(in_valid), .o_in_ready(in_ready),
        .o_out_valid(out_valid), .i_out_ready(out_ready), .o_agtb(agtb), .o_aeqb(aeqb),
        .o_altb(altb), .o_frame_valid(frame_valid), .o_gt_cnt(gt_cnt),
        .o_eq_cnt(eq_cnt), .o_lt_cnt(lt_cnt)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [2:0] r, input logic fv, input int gc, input int ec, input int lc);
        exp_t e;
        e.gt = r[2]; e.eq = r[1]; e.lt = r[0]; e.fv = fv;
        e.gc = 8'(gc); e.ec = 8'(ec); e.lc = 8'(lc);
        return e;
    endfunction

    function automatic exp_t actual();
        return {agtb, aeqb, altb, frame_valid, gt_cnt, eq_cnt, lt_cnt};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every accepted beat is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: got %h expected none at %0t", actual(), $time);
            end else begin
                e = exp_q.pop_front();
                if (actual() !== e) begin
                    errors++;
                    $display("FAIL beat: got %h expected %h at %0t", actual(), e, $time);
                end
            end
        end else if (rst_n && !out_valid) begin
            checks++;
            if (actual() !== '0) begin
                errors++;
                $display("FAIL idle_outputs: got %h expected 0 at %0t", actual(), $time);
            end
        end
    end

    task automatic wait_accept(input string name);
        int n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (in_ready) break;
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got in_ready=0 expected 1 within 100 cycles", name);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        last     = 1'b0;
    endtask

    task automatic send(input logic [3:0] ta, input logic [3:0] tb, input logic tm,
                        input logic tl, input exp_t e);
        a = ta; b = tb; mode = tm; last = tl; in_valid = 1'b1;
        exp_q.push_back(e);
        wait_accept("send");
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("drain_queue", 32'(exp_q.size()), 32'd0);
    endtask

    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] LT = 3'b001;

    initial begin
        rst_n = 1'b0; a = '0; b = '0; mode = 1'b0; last = 1'b0;
        clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_outputs", 32'(actual()), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Sign handling within one frame: gt, lt, lt, eq(last)
        send(4'b0101, 4'b1111, 1'b1, 1'b0, mk(GT, 0, 0, 0, 0));
        send(4'b0101, 4'b1111, 1'b0, 1'b0, mk(LT, 0, 0, 0, 0));
        send(4'b1000, 4'b1011, 1'b1, 1'b0, mk(LT, 0, 0, 0, 0));
        send(4'b0111, 4'b0111, 1'b0, 1'b1, mk(EQ, 1, 1, 1, 2));

        // Four-pair frame, then counts return to zero on the next beat
        send(4'd3, 4'd1, 1'b0, 1'b0, mk(GT, 0, 0, 0, 0));
        send(4'd2, 4'd2, 1'b0, 1'b0, mk(EQ, 0, 0, 0, 0));
        send(4'd1, 4'd3, 1'b0, 1'b0, mk(LT, 0, 0, 0, 0));
        send(4'd9, 4'd2, 1'b0, 1'b1, mk(GT, 1, 2, 1, 1));
        send(4'd1, 4'd1, 1'b0, 1'b0, mk(EQ, 0, 0, 0, 0));
        send(4'd0, 4'd0, 1'b1, 1'b1, mk(EQ, 1, 0, 2, 0));
        drain();

        // Backpressure: second pair waits while the first beat is held
        out_ready = 1'b0;
        send(4'd6, 4'd2, 1'b0, 1'b0, mk(GT, 0, 0, 0, 0));
        a = 4'd2; b = 4'd6; mode = 1'b0; last = 1'b1; in_valid = 1'b1;
        exp_q.push_back(mk(LT, 1, 1, 0, 1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_held_beat", 32'(actual()), 32'(mk(GT, 0, 0, 0, 0)));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_accept("bp");
        drain();

        // Saturation: 300 gt pairs then a closing gt pair
        for (int i = 0; i < 300; i++)
            send(4'd5, 4'd4, 1'b0, 1'b0, mk(GT, 0, 0, 0, 0));
        send(4'd5, 4'd4, 1'b0, 1'b1, mk(GT, 1, 255, 0, 0));
        drain();

        // Single-beat frame
        send(4'd4, 4'd4, 1'b0, 1'b1, mk(EQ, 1, 0, 1, 0));

        // Clear after two beats, then a single-beat frame
        send(4'd3, 4'd1, 1'b0, 1'b0, mk(GT, 0, 0, 0, 0));
        send(4'd1, 4'd3, 1'b0, 1'b0, mk(LT, 0, 0, 0, 0));
        drain();
        clear = 1'b1;
        in_valid = 1'b1; a = 4'd7; b = 4'd0; last = 1'b1;
        @(negedge clk);
        check("clear_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        clear = 1'b0; in_valid = 1'b0; last = 1'b0;
        send(4'd5, 4'd2, 1'b0, 1'b1, mk(GT, 1, 1, 0, 0));
        drain();

        // Reset mid-frame with a pending beat
        out_ready = 1'b0;
        send(4'd1, 4'd0, 1'b0, 1'b0, mk(GT, 0, 0, 0, 0));
        @(negedge clk);
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("post_reset_valid", 32'(out_valid), 32'd0);
        check("post_reset_outputs", 32'(actual()), 32'd0);
        check("post_reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(4'd2, 4'd1, 1'b0, 1'b1, mk(GT, 1, 1, 0, 0));
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_cmp_tracker.md
SEQ_CMP_TRACKER -- requirements
Module: seq_cmp_tracker

Interface
REQ-001 Parameter WIDTH, default 4, sets the operand width in bits (minimum 2).
REQ-002 Parameter CNT_W, default 8, sets the width of the per-frame result counters (minimum 2).
REQ-003 Clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Rst_n  input  1  is the reset: synchronous, active-low.
REQ-005 A  input  WIDTH  is operand A.
REQ-006 B  input  WIDTH  is operand B.
REQ-007 Mode  input  1  selects the comparison: 1 = two's-complement signed, 0 = unsigned.
REQ-008 Last  input  1  marks the final pair of a frame.
REQ-009 Clear  input  1  aborts the current frame.
REQ-010 InValid  input  1  means A, B, Mode and Last are valid.
REQ-011 InReady  output  1  means the block accepts the input pair this cycle.
REQ-012 OutValid  output  1  means the result beat is valid.
REQ-013 OutReady  input  1  means the downstream accepts the result beat.
REQ-014 AgtB, AeqB, AltB  output  1 each  carry the one-hot comparison result.
REQ-015 FrameValid  output  1  means the current result beat closes a frame and carries frame totals.
REQ-016 GtCnt, EqCnt, LtCnt  output  CNT_W each  carry the frame totals, including the closing pair.

Function
REQ-017 An input transfer occurs on an edge where InValid=1 and InReady=1; an output transfer occurs on an edge where OutValid=1 and OutReady=1.
REQ-018 InReady SHALL equal (!OutValid || OutReady) && !Clear, combinationally.
REQ-019 Latency is one cycle: after the edge of an input transfer, OutValid=1 with that pair's results registered.
REQ-020 While OutValid=1 and OutReady=0, all outputs SHALL hold stable.
REQ-021 OutValid clears after an output transfer unless a new input transfer occurs on the same edge, in which case the new beat replaces the old one with no bubble.
REQ-022 In signed mode, operands are interpreted as two's complement; in unsigned mode, as plain binary.
REQ-023 Exactly one of AgtB, AeqB and AltB is 1 whenever OutValid=1; all three are 0 when OutValid=0.
REQ-024 Mode is sampled per transfer; consecutive pairs may use different modes.
REQ-025 Internal running counters gt/eq/lt each increment on their result at every input transfer and saturate at 2^CNT_W-1, with no wrap-around.
REQ-026 The FSM has states IDLE (no frame open) and RUN (frame open).
REQ-027 In IDLE, a transfer with Last=0 goes to RUN.
REQ-028 In IDLE, a transfer with Last=1 is a single-beat frame and the FSM stays in IDLE.
REQ-029 In RUN, a transfer with Last=1 goes to IDLE.
REQ-030 In RUN, a transfer with Last=0 stays in RUN.
REQ-031 On a transfer with Last=1, the result beat has FrameValid=1 and GtCnt/EqCnt/LtCnt = running totals including that pair; the running counters then zero for the next frame.
REQ-032 On non-closing beats, FrameValid=0 and GtCnt/EqCnt/LtCnt=0.
REQ-033 Clear=1 forces the FSM to IDLE and zeroes the running counters on that edge; no input transfer can occur that cycle.
REQ-034 Clear leaves a pending output beat (OutValid, results, FrameValid, counts) unchanged.
REQ-035 Clear in IDLE has no effect beyond zeroing the counters.

Reset
REQ-036 When Rst_n=0 at an edge, the FSM goes to IDLE, the running counters go to 0, and OutValid, AgtB, AeqB, AltB, FrameValid, GtCnt, EqCnt and LtCnt go to 0.
REQ-037 Reset has priority over Clear and over any transfer.
REQ-038 A frame interrupted by reset mid-operation is discarded; no FrameValid is produced for it.
REQ-039 InReady SHALL be 1 in the first cycle after reset release, provided Clear=0.

Verification (WIDTH=4, CNT_W=8)
REQ-040 Mode sign handling: A=0101, B=1111 with Mode=1 -> AgtB=1 (5 > -1); the same pair with Mode=0 -> AltB=1 (5 < 15); A=1000, B=1011 with Mode=1 -> AltB=1 (-8 < -5); A=B=0111 -> AeqB=1.
REQ-041 Frame totals: frame of 4 pairs (gt, eq, lt, gt; Last on the 4th) -> 4th beat has FrameValid=1, GtCnt=2, EqCnt=1, LtCnt=1; the next beat shows counts of 0.
REQ-042 Backpressure: OutReady held 0 for 3 cycles with InValid=1 -> InReady=0 and outputs stable; once OutReady=1, the beats arrive in order with none lost or duplicated.
REQ-043 Saturation: 300 "gt" pairs then Last -> GtCnt=255.
REQ-044 Single-beat frame and Clear: a single-beat frame (Last=1 in IDLE) -> FrameValid=1 with counts of 1; Clear asserted mid-frame after 2 beats, then a 1-beat frame -> counts reflect only that beat.
REQ-045 Reset mid-frame: Rst_n=0 mid-frame with OutValid=1 -> next cycle has OutValid=0, all outputs 0, FSM in IDLE.
